lq_agen_csel_q: RTL
===================

Name: lq_agen_csel_q

Overview:
- In-order resolve buffer that sits after the low-order effective-address byte adder.
- The adder delivers two conditional sums per access: one assuming carry-in 0, one assuming carry-in 1. The real carry into bit 7 (the LSB) comes from the lower offset section, later and in order.
- This block holds each candidate pair, applies the late carry to the oldest unresolved entry, and presents the resolved byte to the downstream address stage with valid/ready flow control.

Parameters:
- DEPTH, 4, number of buffered candidate pairs; power of two, 2..8.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_b  in  1  asynchronous active-low reset.
- cand_val  in  1  candidate pair valid.
- cand_sum_0  in  [0:7]  sum assuming carry-in 0; bit 0 is the MSB.
- cand_sum_1  in  [0:7]  sum assuming carry-in 1.
- cand_rdy  out  1  buffer can accept a candidate pair.
- cin_val  in  1  late carry valid.
- cin  in  1  carry into bit 7.
- flush  in  1  discard all buffered entries.
- err_clr  in  1  clear the sticky error flag.
- ea_val  out  1  head entry resolved and presented.
- ea  out  [0:7]  resolved byte.
- ea_rdy  in  1  downstream accepts ea.
- cin_err  out  1  sticky flag: a carry arrived with no unresolved entry.

Behaviour:
- Reset (rst_b=0, asynchronous):
  - All pointers and count are 0; all resolved and select bits are 0.
  - Outputs: cand_rdy=1, ea_val=0, ea=0x00, cin_err=0.
  - Reset asserted mid-operation drops all entries immediately.
- State per entry: sum_0, sum_1, res (resolved), sel (captured carry).
- Pointers: wr_ptr, res_ptr, rd_ptr, all wrapping modulo DEPTH.
- Counters: count (entries held, 0..DEPTH) and unres (written but not resolved).
- Write:
  - push = cand_val & cand_rdy.
  - cand_rdy = (count != DEPTH), computed from registered state only. A pop in the same cycle does not raise cand_rdy in that cycle.
  - cand_val while cand_rdy=0 is ignored; the source must hold it.
- Carry resolve:
  - When cin_val=1, the entry at res_ptr gets res=1 and sel=cin, then res_ptr advances.
  - If unres=0 and push=1 in the same cycle, the carry resolves the entry being written in that cycle.
  - If unres=0 and push=0, the carry is dropped and cin_err is set.
  - cin_err stays set until err_clr=1 or reset; set has priority over err_clr in the same cycle.
- Output:
  - ea_val = count!=0 & res[rd_ptr].
  - ea = sel[rd_ptr] ? sum_1[rd_ptr] : sum_0[rd_ptr].
  - ea is 0x00 when ea_val=0.
  - ea_val and ea are combinational from registers only; no input reaches an output in the same cycle.
  - pop = ea_val & ea_rdy; it clears res at rd_ptr and advances rd_ptr.
  - ea and ea_val stay stable while ea_val=1 and ea_rdy=0.
- Latency:
  - A candidate and its carry in cycle N give ea_val=1 in cycle N+1.
  - A carry arriving k cycles after its candidate gives ea_val one cycle after the carry.
  - Throughput is one entry per cycle.
- Simultaneous events:
  - Push, resolve and pop may all occur in one cycle.
  - count' = count + push - pop.
  - unres' = unres + push - (cin_val accepted).
- Flush:
  - Synchronous: all pointers, counts and res bits go to 0.
  - Same-cycle push, carry and pop are discarded.
  - cin_err is unaffected.
  - ea_val=0 in the cycle after flush.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.
- Ordering: carries and candidates both arrive in program order; no reordering is performed.

Test Plan:
- Basic: cand_sum_0=0x3A, cand_sum_1=0x3B and cin_val=1, cin=1 together in cycle 0 -> ea_val=1, ea=0x3B in cycle 1. With cin=0 instead -> ea=0x3A.
- Late carry and backpressure:
  - Stimulus: four candidates 0x10/0x11, 0x20/0x21, 0x30/0x31, 0x40/0x41; ea_rdy=0; carries 1,0,1,0 arriving in cycles 6..9.
  - Required: cand_rdy=0 once count=4; a fifth cand_val is ignored.
  - Required after ea_rdy=1: ea sequence 0x11, 0x20, 0x31, 0x40 on consecutive cycles.
- Full with simultaneous push and pop:
  - Stimulus: count=4 with head resolved; ea_rdy=1 and cand_val=1 in the same cycle.
  - Required: pop occurs, push is refused (cand_rdy=0 that cycle), then cand_rdy=1 the next cycle.
- Wrap-around: stream 10 pairs, each with its carry in the same cycle, ea_rdy=1 throughout -> 10 outputs in order, one per cycle, starting at cycle 1; pointers wrap twice with no bubble.
- Orphan carry: cin_val=1 with the buffer empty and no push -> cin_err=1 next cycle; err_clr=1 -> cin_err=0 the cycle after; a flush in between does not clear it.
- Flush and reset:
  - Flush with 3 entries (2 resolved) and a same-cycle push/carry -> ea_val=0, cand_rdy=1, count=0 next cycle.
  - rst_b low mid-stream -> all outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/lq_agen_csel_q.sv
// lq_agen_csel_q: in-order resolve buffer for the low-order EA byte adder.
// Each access delivers two candidate sums (carry-in 0 / carry-in 1). The real
// carry into bit 7 arrives later, in order, and selects one of them. The
// oldest resolved entry is presented downstream under valid/ready.
//
// Ports:
//   clk, rst_b              core clock, async active-low reset
//   cand_val/_sum_0/_sum_1  candidate pair in; cand_rdy = space available
//   cin_val, cin            late carry for the oldest unresolved entry
//   flush                   drop every buffered entry (cin_err kept)
//   err_clr                 clear sticky cin_err
//   ea_val, ea, ea_rdy      resolved byte out (bit 0 = MSB)
//   cin_err                 sticky: a carry arrived with nothing to resolve
module lq_agen_csel_q #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       cand_val,
  input  logic [0:7] cand_sum_0,
  input  logic [0:7] cand_sum_1,
  output logic       cand_rdy,
  input  logic       cin_val,
  input  logic       cin,
  input  logic       flush,
  input  logic       err_clr,
  output logic       ea_val,
  output logic [0:7] ea,
  input  logic       ea_rdy,
  output logic       cin_err
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [0:7]       sum_0 [DEPTH];
  logic [0:7]       sum_1 [DEPTH];
  logic [DEPTH-1:0] res, res_nxt;
  logic [DEPTH-1:0] sel, sel_nxt;
  logic [PTR_W-1:0] wr_ptr, res_ptr, rd_ptr;
  logic [PTR_W:0]   count, unres;

  logic push, pop, cin_take, cin_drop;

  // cand_rdy looks only at registered count: a same-cycle pop does not help.
  assign cand_rdy = (count != CNT_FULL);
  assign push     = cand_val & cand_rdy;

  // With nothing unresolved, a carry can still land on the entry being
  // written this cycle (res_ptr == wr_ptr in that case).
  assign cin_take = cin_val & ((unres != '0) | push);
  assign cin_drop = cin_val & ~cin_take;

  assign ea_val = (count != '0) & res[rd_ptr];
  assign ea     = ea_val ? (sel[rd_ptr] ? sum_1[rd_ptr] : sum_0[rd_ptr]) : 8'h00;
  assign pop    = ea_val & ea_rdy;

  // Per-entry flag update. Write clears res first so a same-cycle carry on
  // the same slot wins. Pop and resolve never target the same slot.
  always_comb begin
    res_nxt = res;
    sel_nxt = sel;
    if (push) res_nxt[wr_ptr] = 1'b0;
    if (cin_take) begin
      res_nxt[res_ptr] = 1'b1;
      sel_nxt[res_ptr] = cin;
    end
    if (pop)   res_nxt[rd_ptr] = 1'b0;
    if (flush) res_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr  <= '0;
      res_ptr <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      unres   <= '0;
      res     <= '0;
      sel     <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      res_ptr <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      unres   <= '0;
      res     <= res_nxt;
      sel     <= sel_nxt;
    end else begin
      if (push)     wr_ptr  <= wr_ptr + PTR_W'(1);
      if (cin_take) res_ptr <= res_ptr + PTR_W'(1);
      if (pop)      rd_ptr  <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      unres <= unres + (PTR_W+1)'(push) - (PTR_W+1)'(cin_take);
      res   <= res_nxt;
      sel   <= sel_nxt;
    end
  end

  // Candidate payload needs no reset: it is only visible once res is set.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      sum_0[wr_ptr] <= cand_sum_0;
      sum_1[wr_ptr] <= cand_sum_1;
    end
  end

  // Sticky orphan-carry flag; a new orphan beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)        cin_err <= 1'b0;
    else if (cin_drop) cin_err <= 1'b1;
    else if (err_clr)  cin_err <= 1'b0;
  end

endmodule
